mfp_button_event_ctrl: RTL

//  Event controller behind the per-pin debouncers for board buttons/switches.
//  - Watches WIDTH debounced levels and detects masked rise/fall edges.
//  - Arbitrates simultaneous edges round-robin into a small event FIFO.
//  - Presents events to the CPU-side bus glue over a valid/ready pop port.
//  - Raises a level interrupt while events are queued.

---
 rtl/mfp_btn_pkg.sv | 16 +
 rtl/mfp_btn_event_fifo.sv | 55 +++++
 rtl/mfp_button_event_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mfp_btn_pkg.sv
// Shared types and helpers for the button event controller.
package mfp_btn_pkg;

  // Pin field sized for the largest supported WIDTH (32 pins).
  localparam int unsigned PIN_W = 5;

  typedef struct packed {
    logic [PIN_W-1:0] pin;
    logic             rise;
  } btn_event_t;

  function automatic int unsigned pin_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mfp_btn_event_fifo.sv
// Synchronous event FIFO; push is refused while full even if a pop coincides.
module mfp_btn_event_fifo
  import mfp_btn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  btn_event_t               din,
  input  logic                     pop,
  output btn_event_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  btn_event_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mfp_button_event_ctrl.sv
// Button event controller: masked edge detect, per-pin pending latches,
// round-robin arbitration into an event FIFO, and a registered interrupt.
module mfp_button_event_ctrl
  import mfp_btn_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              in_db,
  input  logic [WIDTH-1:0]              rise_mask,
  input  logic [WIDTH-1:0]              fall_mask,
  input  logic                          irq_en,
  input  logic                          ev_ready,
  output logic                          ev_valid,
  output logic [$clog2(WIDTH)-1:0]      ev_pin,
  output logic                          ev_rise,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          irq
);

  localparam int unsigned PW = pin_w(WIDTH);

  logic              armed;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  pend;
  logic [WIDTH-1:0]  kind;
  logic [WIDTH-1:0]  rise_det;
  logic [WIDTH-1:0]  fall_det;
  logic [WIDTH-1:0]  edge_det;
  logic [WIDTH-1:0]  grant;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     grant_idx;
  logic              grant_vld;
  logic              ovf_loss;
  int unsigned       scan_idx;
  btn_event_t        push_ev;
  btn_event_t        head;
  logic              fifo_full;
  logic              fifo_empty;

  always_comb begin
    rise_det = '0;
    fall_det = '0;
    if (armed) begin
      rise_det = in_db & ~prev & rise_mask;
      fall_det = ~in_db & prev & fall_mask;
    end
  end

  assign edge_det = rise_det | fall_det;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    if (!fifo_full) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        scan_idx = (32'(rr_ptr) + k) % WIDTH;
        if (!grant_vld && pend[scan_idx]) begin
          grant_vld        = 1'b1;
          grant_idx        = PW'(scan_idx);
          grant[scan_idx]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    push_ev      = '0;
    push_ev.pin  = PIN_W'(grant_idx);
    push_ev.rise = kind[grant_idx];
  end

  // A fresh edge on a pin that is being granted this cycle is not a loss.
  assign ovf_loss = |(edge_det & pend & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      prev     <= '0;
      pend     <= '0;
      kind     <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      armed    <= 1'b1;
      prev     <= in_db;
      pend     <= (pend & ~grant) | edge_det;
      kind     <= (kind & ~edge_det) | rise_det;
      overflow <= ovf_loss | (overflow & ~ovf_clr);
      irq      <= irq_en & ev_valid;
      if (grant_vld)
        rr_ptr <= (grant_idx == PW'(WIDTH-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  mfp_btn_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_vld),
    .din   (push_ev),
    .pop   (ev_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ev_count)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_pin   = ev_valid ? PW'(head.pin) : '0;
  assign ev_rise  = ev_valid & head.rise;

endmodule
